// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one single-port synchronous SRAM among NUM_CH requesters.
// Optional grant/contention counters are built only when SRAM_PORT_ARBITER_PERF_EN is defined.
module sram_port_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req_valid,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_web,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
    output logic [NUM_CH-1:0]            rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         sram_cs,
    output logic                         sram_oe,
    output logic [(DATA_W/8)-1:0]        sram_web,
    output logic [ADDR_W-1:0]            sram_a,
    output logic [DATA_W-1:0]            sram_di,
    input  logic [DATA_W-1:0]            sram_do,
    output logic [NUM_CH*16-1:0]         perf_grant_cnt,
    output logic [15:0]                  perf_conflict_cnt
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              gnt_found;
    logic [PTR_W-1:0]  gnt_idx;

    function automatic int wrap_ch(input int i);
        return (i >= NUM_CH) ? i - NUM_CH : i;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage 0: arbitration and SRAM drive; no grants while reset is held
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        sram_cs   = 1'b0;
        sram_web  = '1;
        sram_a    = '0;
        sram_di   = '0;
        rr_ptr_d  = rr_ptr_q;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_found && req_valid[wrap_ch(int'(rr_ptr_q) + i)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(wrap_ch(int'(rr_ptr_q) + i));
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
            sram_cs  = 1'b1;
            sram_web = req_web[int'(gnt_idx)*BE_W +: BE_W];
            sram_a   = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
            sram_di  = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
            rr_ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign sram_oe     = 1'b1;
    assign rsp_valid_d = (gnt_found && (&sram_web)) ? req_ready : '0;

    // Stage 1: read response; SRAM data is live in the cycle after the access edge
    always_comb begin
        rdata_d = rdata_q;
        if (|rsp_valid_q) begin
            rdata_d = sram_do;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef SRAM_PORT_ARBITER_PERF_EN
    logic [NUM_CH*16-1:0] grant_cnt_q, grant_cnt_d;
    logic [15:0]          conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_ready[k]) begin
                grant_cnt_d[k*16 +: 16] = sat_inc(grant_cnt_q[k*16 +: 16]);
            end
        end
        conflict_cnt_d = conflict_cnt_q;
        if ($countones(req_valid) >= 2) begin
            conflict_cnt_d = sat_inc(conflict_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            grant_cnt_q    <= grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign perf_grant_cnt    = grant_cnt_q;
    assign perf_conflict_cnt = conflict_cnt_q;
`else
    assign perf_grant_cnt    = '0;
    assign perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a 2-channel and a 4-channel instance, each with a behavioural SRAM.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 2-channel instance
    logic [1:0]  v2 = '0;
    logic [1:0]  rdy2;
    logic [27:0] addr2 = '0;
    logic [7:0]  web2 = '1;
    logic [63:0] wdata2 = '0;
    logic [1:0]  rspv2;
    logic [31:0] rdata2;
    logic        cs2, oe2;
    logic [3:0]  sweb2;
    logic [13:0] sa2;
    logic [31:0] sdi2, sdo2;
    logic [31:0] pg2;
    logic [15:0] pc2;

    sram_port_arbiter #(.NUM_CH(2), .ADDR_W(14), .DATA_W(32)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_addr(addr2),
        .req_web(web2), .req_wdata(wdata2), .rsp_valid(rspv2), .rsp_rdata(rdata2),
        .sram_cs(cs2), .sram_oe(oe2), .sram_web(sweb2), .sram_a(sa2), .sram_di(sdi2),
        .sram_do(sdo2), .perf_grant_cnt(pg2), .perf_conflict_cnt(pc2)
    );

    // 4-channel instance, read-only traffic
    logic [3:0]   v4 = '0;
    logic [3:0]   rdy4;
    logic [55:0]  addr4 = '0;
    logic [15:0]  web4 = '1;
    logic [127:0] wdata4 = '0;
    logic [3:0]   rspv4;
    logic [31:0]  rdata4;
    logic         cs4, oe4;
    logic [3:0]   sweb4;
    logic [13:0]  sa4;
    logic [31:0]  sdi4, sdo4;
    logic [63:0]  pg4;
    logic [15:0]  pc4;

    sram_port_arbiter #(.NUM_CH(4), .ADDR_W(14), .DATA_W(32)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_addr(addr4),
        .req_web(web4), .req_wdata(wdata4), .rsp_valid(rspv4), .rsp_rdata(rdata4),
        .sram_cs(cs4), .sram_oe(oe4), .sram_web(sweb4), .sram_a(sa4), .sram_di(sdi4),
        .sram_do(sdo4), .perf_grant_cnt(pg4), .perf_conflict_cnt(pc4)
    );

    // Behavioural single-port synchronous SRAMs
    logic [31:0] mem2 [0:16383];
    logic [31:0] mem4 [0:16383];

    always @(posedge clk) begin
        if (cs2) begin
            if (&sweb2) sdo2 <= mem2[sa2];
            else for (int b = 0; b < 4; b++) if (!sweb2[b]) mem2[sa2][b*8 +: 8] <= sdi2[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (cs4) begin
            if (&sweb4) sdo4 <= mem4[sa4];
            else for (int b = 0; b < 4; b++) if (!sweb4[b]) mem4[sa4][b*8 +: 8] <= sdi4[b*8 +: 8];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int ch, input logic v, input logic [13:0] a,
                        input logic [3:0] w, input logic [31:0] d);
        v2[ch] = v;
        addr2[ch*14 +: 14] = a;
        web2[ch*4 +: 4] = w;
        wdata2[ch*32 +: 32] = d;
    endtask

    initial begin
        logic [3:0] exp4;

        // Reset state
        repeat (3) tick();
        chk("rst_rspv", rspv2, 2'b00);
        chk("rst_rdata", rdata2, 32'h0);
        chk("rst_ready", rdy2, 2'b00);
        chk("rst_cs", cs2, 1'b0);
        chk("rst_web", sweb2, 4'hF);
        chk("rst_a", sa2, 14'h0);
        chk("rst_di", sdi2, 32'h0);
        chk("rst_oe", oe2, 1'b1);
        chk("rst_rspv4", rspv4, 4'h0);
        rst = 1'b1;
        tick();

        // Single write then read on ch1
        set2(1, 1'b1, 14'h0010, 4'h0, 32'hDEADBEEF);
        #1;
        chk("wr_ready", rdy2, 2'b10);
        chk("wr_cs", cs2, 1'b1);
        chk("wr_a", sa2, 14'h0010);
        chk("wr_web", sweb2, 4'h0);
        chk("wr_di", sdi2, 32'hDEADBEEF);
        tick();
        chk("wr_norsp", rspv2, 2'b00);
        set2(1, 1'b1, 14'h0010, 4'hF, 32'h0);
        #1;
        chk("rd_ready", rdy2, 2'b10);
        tick();
        set2(1, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("rd_rspv", rspv2, 2'b10);
        chk("rd_rdata", rdata2, 32'hDEADBEEF);
        tick();
        chk("rd_rspv_off", rspv2, 2'b00);
        chk("rd_hold", rdata2, 32'hDEADBEEF);
        chk("idle_cs", cs2, 1'b0);

        // Byte write on ch0, then read-after-write
        set2(0, 1'b1, 14'h0020, 4'h0, 32'h11223344);
        tick();
        set2(0, 1'b1, 14'h0020, 4'b1110, 32'hAABBCCDD);
        #1;
        chk("bw_web", sweb2, 4'b1110);
        tick();
        set2(0, 1'b1, 14'h0020, 4'hF, 32'h0);
        tick();
        set2(0, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("bw_rspv", rspv2, 2'b01);
        chk("bw_rdata", rdata2, 32'h112233DD);

        // Contention with rr_ptr=1
        tick();
        set2(0, 1'b1, 14'h0010, 4'hF, 32'h0);
        set2(1, 1'b1, 14'h0020, 4'hF, 32'h0);
        #1;
        chk("ct_ready1", rdy2, 2'b10);
        chk("ct_a1", sa2, 14'h0020);
        tick();
        set2(1, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("ct_rspv1", rspv2, 2'b10);
        chk("ct_rdata1", rdata2, 32'h112233DD);
        #1;
        chk("ct_ready0", rdy2, 2'b01);
        chk("ct_a0", sa2, 14'h0010);
        tick();
        set2(0, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("ct_rspv0", rspv2, 2'b01);
        chk("ct_rdata0", rdata2, 32'hDEADBEEF);

        // Round-robin on the 4-channel instance
        for (int k = 0; k < 4; k++) addr4[k*14 +: 14] = 14'(k + 1);
        v4 = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
            exp4 = 4'b0001 << (c % 4);
            chk("rr_ready", rdy4, exp4);
            chk("rr_a", sa4, 14'((c % 4) + 1));
            exp4 = (c == 0) ? 4'b0000 : (4'b0001 << ((c - 1) % 4));
            chk("rr_rspv", rspv4, exp4);
            tick();
        end
        v4 = 4'h0;
        chk("rr_rspv_last", rspv4, 4'b1000);
        tick();
        chk("rr_rspv_idle", rspv4, 4'b0000);

        // Asynchronous reset while ch0 read is waiting; rr_ptr (was 1) must return to 0
        set2(0, 1'b1, 14'h0010, 4'hF, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_ready", rdy2, 2'b00);
        chk("mr_cs", cs2, 1'b0);
        chk("mr_rdata", rdata2, 32'h0);
        tick();
        chk("mr_rspv", rspv2, 2'b00);
        chk("mr_rdata2", rdata2, 32'h0);
        rst = 1'b1;
        set2(1, 1'b1, 14'h0020, 4'hF, 32'h0);
        #1;
        chk("mr_ptr0", rdy2, 2'b01);
        chk("mr_a", sa2, 14'h0010);
        tick();
        set2(0, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("mr_rspv0", rspv2, 2'b01);
        chk("mr_rdata0", rdata2, 32'hDEADBEEF);
        #1;
        chk("mr_ready1", rdy2, 2'b10);
        tick();
        set2(1, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("mr_rspv1", rspv2, 2'b10);
        chk("mr_rdata1", rdata2, 32'h112233DD);
        tick();

`ifdef SRAM_PORT_ARBITER_PERF_EN
        // Counters: 3 contention cycles, then ch0 alone long enough to saturate
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("pf_rst", pc2, 16'h0);
        set2(0, 1'b1, 14'h0030, 4'h0, 32'h1);
        set2(1, 1'b1, 14'h0031, 4'h0, 32'h2);
        repeat (3) tick();
        set2(1, 1'b0, 14'h0, 4'hF, 32'h0);
        chk("pf_g0_mid", pg2[15:0], 16'd2);
        repeat (70000) tick();
        set2(0, 1'b0, 14'h0, 4'hF, 32'h0);
        tick();
        chk("pf_conflict", pc2, 16'd3);
        chk("pf_g0_sat", pg2[15:0], 16'hFFFF);
        chk("pf_g1", pg2[31:16], 16'd1);
`else
        chk("pf_off_g2", pg2, 32'h0);
        chk("pf_off_c2", pc2, 16'h0);
        chk("pf_off_g4", pg4, 64'h0);
        chk("pf_off_c4", pc4, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Unused 4-channel outputs kept observable for completeness
    logic unused_ok;
    assign unused_ok = ^{rdata4, oe4, sdi4, sweb4, wdata4, web4};
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM wrapper (14-bit word address, 32-bit data, active-low byte write enables) among NUM_CH requesters.
- Successor to the fixed one-CPU-port-per-SRAM hookup in the top level. Lets instruction fetch, load/store and DMA-style masters share one bank.
- Uses round-robin arbitration, a valid/ready request handshake and a registered read-response strobe.

Parameters:
- NUM_CH, 2, number of requester channels (legal 1..8)
- ADDR_W, 14, SRAM word address width
- DATA_W, 32, data width; must be a multiple of 8
- BE_W, DATA_W/8, byte-lane count (derived, not overridable)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel grant; a transfer occurs when valid & ready
- req_addr  in  NUM_CH*ADDR_W  packed word addresses; channel k at [k*ADDR_W +: ADDR_W]
- req_web  in  NUM_CH*BE_W  packed active-low byte write enables; all ones = read
- req_wdata  in  NUM_CH*DATA_W  packed write data
- rsp_valid  out  NUM_CH  one-cycle read-data strobe per channel
- rsp_rdata  out  DATA_W  read data, shared by all channels, qualified by rsp_valid
- sram_cs  out  1  SRAM chip select
- sram_oe  out  1  SRAM output enable, tied 1
- sram_web  out  BE_W  SRAM byte write enables, active low
- sram_a  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data, valid in the cycle after the access edge
- perf_grant_cnt  out  NUM_CH*16  per-channel grant counters (optional feature)
- perf_conflict_cnt  out  16  contention-cycle counter (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): rr_ptr=0, rsp_valid=0, rsp_rdata=0, perf counters=0.
- Reset deassertion is synchronised externally.
- Reset mid-operation drops any pending response; no rsp_valid is issued for the killed access.
- Arbitration (combinational, each cycle):
  - Scan channels starting at rr_ptr, wrapping modulo NUM_CH. The first channel with req_valid=1 is granted.
  - At most one req_ready bit is high. req_ready[k] is 0 whenever req_valid[k]=0.
  - req_ready may depend combinationally on req_valid.
- On a grant to channel g: sram_cs=1, sram_a=addr[g], sram_web=web[g], sram_di=wdata[g]. Registered rr_ptr becomes (g+1) mod NUM_CH.
- No grant: sram_cs=0, sram_web all ones, sram_a=0, sram_di=0, rr_ptr unchanged.
- One access per cycle; a granted channel may issue back-to-back only when no other channel is valid.
- Read (web all ones) accepted at edge N: rsp_valid[g]=1 for exactly cycle N+1, with rsp_rdata=sram_do.
- rsp_rdata is driven from sram_do only in cycles where some rsp_valid is high. It holds its last value otherwise.
- Write (any web bit 0): no response. Completion is the handshake itself.
- Partial write: only lanes with web=0 are updated, handled by the SRAM. Arbiter passes web unmodified.
- A read issued in cycle N+1 to an address written in cycle N returns the new data, since SRAM ordering is preserved.
- Responses cannot be back-pressured. A requester must accept rsp_valid in the cycle it appears.
- Requester rule: once req_valid is raised, it and its payload are held until the handshake. The arbiter does not check this.
- Fairness: with all channels continuously valid, each channel is granted exactly once per NUM_CH cycles.
- NUM_CH=1 degenerates to a pass-through with a registered response; rr_ptr is constant 0.

Optional Feature:
- Macro: SRAM_PORT_ARBITER_PERF_EN.
- Defined:
  - perf_grant_cnt[k] increments on each grant to channel k.
  - perf_conflict_cnt increments in each cycle where two or more req_valid bits are high.
  - All counters are 16-bit, saturate at 16'hFFFF, and are cleared by reset.
- Undefined: both perf ports are driven constant 0 and no counter flops are synthesised.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle while ch0 read is pending -> rsp_valid stays 0, all outputs at reset values, rr_ptr=0 after release.
- Single read: NUM_CH=2; ch1 writes 32'hDEADBEEF to 0x0010 with web=4'h0, then reads 0x0010 -> read handshake at N, rsp_valid=2'b10 at N+1, rsp_rdata=32'hDEADBEEF.
- Byte write: preload 0x0020=32'h11223344; ch0 writes 32'hAABBCCDD with web=4'b1110; ch0 reads 0x0020 -> rsp_rdata=32'h112233DD.
- Round-robin: NUM_CH=4, all valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each channel gets one rsp_valid pulse per 4 cycles.
- Contention: ch0 and ch1 valid at the same edge with rr_ptr=1 -> ch1 granted first, ch0 granted next cycle with its payload held.
- Perf (macro defined): 3 contention cycles plus 70000 ch0 grants -> perf_conflict_cnt=3, perf_grant_cnt[0] saturates at 16'hFFFF.
